// File: rtl/adder_arb_pkg.sv
// adder_arb_pkg: shared types and constants for the adder-sharing arbiter.
//   state_t   - sequencer states (IDLE, SETTLE, RESP)
//   WIDTH_DEF - default operand/sum width of the shared adder
//   req_id_t  - requester identifier (0 or 1)
package adder_arb_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    RESP   = 2'd2
  } state_t;

  typedef logic req_id_t;

endpackage

// File: rtl/arb2_grant.sv
// arb2_grant: combinational two-way grant for the shared adder.
//   valid0, valid1 - request present from requester 0 / 1
//   last_served    - requester whose response was most recently accepted
//   grant          - one-hot grant (bit N = requester N), zero when idle
// Build option ADDER_ARB_ROUND_ROBIN_EN: when defined, a tie goes to the
// requester that was not last served; otherwise requester 0 always wins.
module arb2_grant
  import adder_arb_pkg::*;
(
  input  logic       valid0,
  input  logic       valid1,
  input  req_id_t    last_served,
  output logic [1:0] grant
);

`ifdef ADDER_ARB_ROUND_ROBIN_EN
  always_comb begin
    grant = 2'b00;
    if (valid0 && valid1) begin
      grant = (last_served == 1'b1) ? 2'b01 : 2'b10;
    end else if (valid0) begin
      grant = 2'b01;
    end else if (valid1) begin
      grant = 2'b10;
    end
  end
`else
  // Fixed priority: history is kept by the caller but plays no part here.
  logic unused_last_served;
  assign unused_last_served = last_served;

  always_comb begin
    grant = 2'b00;
    if (valid0) begin
      grant = 2'b01;
    end else if (valid1) begin
      grant = 2'b10;
    end
  end
`endif

endmodule

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: shares one add/subtract datapath between two clients.
// A granted request's operands are registered onto the adder inputs, held for
// SETTLE_CYCLES clocks to cover the ripple-carry delay, then the adder's sum
// and flags are captured and returned over a valid/ready response tagged with
// the requester ID.
// Ports:
//   clk, rst_n                       - clock, asynchronous active-low reset
//   reqN_valid/ready                 - request handshake for requester N
//   reqN_a, reqN_b, reqN_sub         - operands and subtract select
//   add_a, add_b, add_subtract       - registered drive to the adder
//   add_sum, add_carryout, add_overflow - adder results
//   rsp_valid/ready, rsp_id          - response handshake and owner
//   rsp_sum, rsp_carryout, rsp_overflow - captured results
// Build option ADDER_ARB_ROUND_ROBIN_EN selects round-robin arbitration
// (see arb2_grant); fixed priority to requester 0 otherwise.
module adder_share_arbiter
  import adder_arb_pkg::*;
#(
  parameter int WIDTH         = WIDTH_DEF,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sub,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sub,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_subtract,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_carryout,
  input  logic             add_overflow,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output req_id_t          rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_carryout,
  output logic             rsp_overflow
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);

  state_t        state;
  logic [CW-1:0] cnt;
  req_id_t       last_served;
  req_id_t       cur_id;
  logic [1:0]    grant;
  logic          accept;

  arb2_grant u_grant (
    .valid0      (req0_valid),
    .valid1      (req1_valid),
    .last_served (last_served),
    .grant       (grant)
  );

  // Grant already includes the valid, so a ready implies a handshake.
  assign req0_ready = (state == IDLE) && grant[0];
  assign req1_ready = (state == IDLE) && grant[1];
  assign accept     = req0_ready || req1_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      last_served  <= 1'b1;
      cur_id       <= 1'b0;
      add_a        <= '0;
      add_b        <= '0;
      add_subtract <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_id       <= 1'b0;
      rsp_sum      <= '0;
      rsp_carryout <= 1'b0;
      rsp_overflow <= 1'b0;
    end else begin
      case (state)
        // Accept: launch the granted operands onto the adder.
        IDLE: begin
          if (accept) begin
            add_a        <= grant[1] ? req1_a   : req0_a;
            add_b        <= grant[1] ? req1_b   : req0_b;
            add_subtract <= grant[1] ? req1_sub : req0_sub;
            cur_id       <= grant[1];
            cnt          <= CW'(SETTLE_CYCLES - 1);
            state        <= SETTLE;
          end
        end
        // Settle: adder inputs frozen until the carry chain has resolved.
        SETTLE: begin
          if (cnt == '0) begin
            rsp_sum      <= add_sum;
            rsp_carryout <= add_carryout;
            rsp_overflow <= add_overflow;
            rsp_id       <= cur_id;
            rsp_valid    <= 1'b1;
            state        <= RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        // Respond: hold the captured result until the consumer takes it.
        RESP: begin
          if (rsp_valid && rsp_ready) begin
            rsp_valid   <= 1'b0;
            last_served <= rsp_id;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
module tb_adder_share_arbiter;
  localparam int W  = 32;
  localparam int SC = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid, req0_ready, req0_sub;
  logic          req1_valid, req1_ready, req1_sub;
  logic [W-1:0]  req0_a, req0_b, req1_a, req1_b;
  logic [W-1:0]  add_a, add_b, add_sum;
  logic          add_subtract, add_carryout, add_overflow;
  logic          rsp_valid, rsp_ready, rsp_id;
  logic [W-1:0]  rsp_sum;
  logic          rsp_carryout, rsp_overflow;

  int tests = 0;
  int fails = 0;
  bit last_m = 1'b1;   // model of the last requester served

  always #5 clk = ~clk;

  adder_share_arbiter #(.WIDTH(W), .SETTLE_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
    .add_a(add_a), .add_b(add_b), .add_subtract(add_subtract),
    .add_sum(add_sum), .add_carryout(add_carryout), .add_overflow(add_overflow),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_sum(rsp_sum), .rsp_carryout(rsp_carryout), .rsp_overflow(rsp_overflow)
  );

  // Stand-in for the external ripple-carry adder (a + ~b + 1 when subtracting).
  logic [W-1:0] bb;
  logic [W:0]   full;
  assign bb           = add_subtract ? ~add_b : add_b;
  assign full         = {1'b0, add_a} + {1'b0, bb} + {{W{1'b0}}, add_subtract};
  assign add_sum      = full[W-1:0];
  assign add_carryout = full[W];
  assign add_overflow = (add_a[W-1] == bb[W-1]) && (full[W-1] != add_a[W-1]);

  // Reference: {overflow, carryout, sum} from integer arithmetic.
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input bit sub);
    longint sa, sb, r;
    logic [W-1:0] s;
    bit c, o;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = sub ? sa - sb : sa + sb;
    s  = r[W-1:0];
    o  = (r != longint'($signed(s)));
    if (sub) c = (a >= b);
    else     c = ({1'b0, a} + {1'b0, b}) > {1'b0, {W{1'b1}}};
    return {o, c, s};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One full transaction from a single requester; caller is just after an edge.
  task automatic do_op(input bit id, input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit sub, input logic [W+1:0] e, input int stall,
                       input string tag);
    int n;
    if (id) begin req1_valid = 1; req1_a = a; req1_b = b; req1_sub = sub; end
    else    begin req0_valid = 1; req0_a = a; req0_b = b; req0_sub = sub; end
    #1;
    chk({tag, " ready"}, id ? req1_ready : req0_ready, 1);
    chk({tag, " other ready"}, id ? req0_ready : req1_ready, 0);
    @(posedge clk); #1;
    req0_valid = 0; req1_valid = 0;
    chk({tag, " add_ops"}, {add_a, add_b}, {a, b});
    chk({tag, " add_sub"}, add_subtract, sub);
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk({tag, " latency"}, n, SC);
    chk({tag, " rsp_sum"}, rsp_sum, e[W-1:0]);
    chk({tag, " flags"}, {rsp_overflow, rsp_carryout}, e[W+1:W]);
    chk({tag, " rsp_id"}, rsp_id, id);
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      chk({tag, " hold"}, {rsp_valid, rsp_sum}, {1'b1, e[W-1:0]});
    end
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    last_m = id;
    chk({tag, " rsp_valid clr"}, rsp_valid, 0);
  endtask

  // Both requesters continuously valid, consumer always ready.
  task automatic both_valid(input int k);
    int n;
    bit eid;
    req0_valid = 1; req0_a = 32'd10; req0_b = 32'd1; req0_sub = 0;
    req1_valid = 1; req1_a = 32'd20; req1_b = 32'd3; req1_sub = 1;
    rsp_ready = 1;
    for (int i = 0; i < k; i++) begin
`ifdef ADDER_ARB_ROUND_ROBIN_EN
      eid = ~last_m;
`else
      eid = 1'b0;
`endif
      n = 0;
      while (!rsp_valid && n < 50) begin
        @(posedge clk); #1; n++;
      end
      chk("both rsp_valid", rsp_valid, 1);
      chk("both grant id", rsp_id, eid);
      chk("both sum", rsp_sum, eid ? 32'd17 : 32'd11);
      last_m = eid;
      if (i == k - 1) begin req0_valid = 0; req1_valid = 0; end
      @(posedge clk); #1;
    end
    rsp_ready = 0;
  endtask

  typedef struct {
    bit           id;
    logic [W-1:0] a, b;
    bit           sub;
    logic [W-1:0] sum;
    bit           c, o;
  } vec_t;

  vec_t tbl[6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  n;
    bit  seen;
    bit  rid;
    logic [W-1:0] ra, rb;
    bit  rsub;

    tbl[0] = '{0, 32'd5,          32'd7,          0, 32'd12,         0, 0};
    tbl[1] = '{1, 32'd3,          32'd5,          1, 32'hFFFFFFFE,   0, 0};
    tbl[2] = '{0, 32'h7FFFFFFF,   32'd1,          0, 32'h80000000,   0, 1};
    tbl[3] = '{1, 32'hFFFFFFFF,   32'd1,          0, 32'h00000000,   1, 0};
    tbl[4] = '{0, 32'h80000000,   32'd1,          1, 32'h7FFFFFFF,   1, 1};
    tbl[5] = '{1, 32'd0,          32'd0,          1, 32'h00000000,   1, 0};

    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_a = 0; req0_b = 0; req0_sub = 0;
    req1_a = 0; req1_b = 0; req1_sub = 0;

    #2;
    chk("reset add", {add_a, add_b, add_subtract}, 0);
    chk("reset rsp", {rsp_valid, rsp_id, rsp_sum, rsp_carryout, rsp_overflow}, 0);
    chk("reset ready", {req0_ready, req1_ready}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;

    // Directed vectors
    for (int i = 0; i < 6; i++)
      do_op(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].sub,
            {tbl[i].o, tbl[i].c, tbl[i].sum}, 0, $sformatf("vec%0d", i));

    // Random single-requester traffic against the reference model
    for (int i = 0; i < 30; i++) begin
      rid  = 1'($urandom_range(0, 1));
      ra   = $urandom;
      rb   = $urandom;
      rsub = 1'($urandom_range(0, 1));
      do_op(rid, ra, rb, rsub, ref_add(ra, rb, rsub), $urandom_range(0, 2),
            $sformatf("rnd%0d", i));
    end

    // Stalled consumer: a second request must wait out the handshake
    req0_valid = 1; req0_a = 32'd100; req0_b = 32'd23; req0_sub = 1;
    #1;
    @(posedge clk); #1;
    req0_valid = 0;
    req1_valid = 1; req1_a = 32'd8; req1_b = 32'd9; req1_sub = 0;
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("stall latency", n, SC);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (req0_ready || req1_ready || !rsp_valid || rsp_sum != 32'd77 || rsp_id != 1'b0)
        seen = 1;
      @(posedge clk); #1;
    end
    chk("stall hold/ready low", seen, 0);
    chk("stall rsp_sum", rsp_sum, 32'd77);
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    last_m = 0;
    chk("stall next grant", {req1_ready, req0_ready}, 2'b10);
    @(posedge clk); #1;
    req1_valid = 0;
    n = 0;
    while (!rsp_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("stall req1 id", rsp_id, 1);
    chk("stall req1 sum", rsp_sum, 32'd17);
    rsp_ready = 1;
    @(posedge clk); #1;
    rsp_ready = 0;
    last_m = 1;

    // Arbitration with both requesters always valid
    both_valid(4);

    // Reset pulsed during SETTLE
    req1_valid = 1; req1_a = 32'd1234; req1_b = 32'd1; req1_sub = 0;
    #1;
    @(posedge clk); #1;
    req1_valid = 0;
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    chk("midrst add", {add_a, add_b, add_subtract}, 0);
    chk("midrst rsp", {rsp_valid, rsp_id, rsp_sum, rsp_carryout, rsp_overflow}, 0);
    last_m = 1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    seen = 0;
    for (int i = 0; i < SC + 3; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen = 1;
    end
    chk("midrst no rsp", seen, 0);
    do_op(1, 32'd40, 32'd2, 0, ref_add(32'd40, 32'd2, 0), 0, "postrst");

    // Fresh reset: round-robin starts with req0
    rst_n = 0;
    #1;
    last_m = 1;
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    both_valid(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
